// File: rtl/counter_updown_pkg.sv
// counter_updown_pkg: shared direction/mode encodings and width helper for the up/down counter
package counter_updown_pkg;
    localparam logic DIR_DOWN  = 1'b0;
    localparam logic DIR_UP    = 1'b1;
    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < v) r = i + 1;
        return r;
    endfunction
endpackage

// File: rtl/counter_updown_prescaler.sv
// counter_updown_prescaler: divides enabled cycles into one tick every Prescale enabled cycles
module counter_updown_prescaler
    import counter_updown_pkg::*;
#(
    parameter int Prescale = 1
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic tick
);
    localparam int W = (clog2(Prescale) < 1) ? 1 : clog2(Prescale);
    localparam logic [W-1:0] LAST = W'(Prescale - 1);
    logic [W-1:0] cnt;
    assign tick = enable && cnt == LAST;
    // advance on enabled cycles, restart on tick, clear or reset
    always_ff @(posedge clock)
        if (reset || clear) cnt <= '0;
        else if (enable) cnt <= tick ? '0 : cnt + 1'b1;
endmodule

// File: rtl/counter_updown.sv
// counter_updown: prescaled up/down counter with load, modulo limit, wrap/saturate and event pulses
// Optional sticky overflow flag with clear_flags input: define COUNTER_UPDOWN_STICKY_EN
module counter_updown
    import counter_updown_pkg::*;
#(
    parameter int Size = 5,
    parameter logic [Size-1:0] Limit = {Size{1'b1}},
    parameter int Prescale = 1
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            enable,
    input  logic            up,
    input  logic            saturate,
    input  logic            load,
    input  logic [Size-1:0] load_value,
`ifdef COUNTER_UPDOWN_STICKY_EN
    input  logic            clear_flags,
    output logic            overflow,
`endif
    output logic [Size-1:0] count,
    output logic            tc,
    output logic            wrapped
);
    logic tick, at_bound, hold;
    logic [Size-1:0] bound, next;
    counter_updown_prescaler #(.Prescale(Prescale)) u_pre (
        .clock(clock), .reset(reset), .enable(enable), .clear(load), .tick(tick)
    );
    assign bound    = (up == DIR_UP) ? Limit : '0;
    assign at_bound = count == bound;
    assign hold     = saturate == MODE_SAT;
    assign next     = at_bound ? (hold ? count : (up == DIR_UP ? '0 : Limit))
                               : (up == DIR_UP ? count + 1'b1 : count - 1'b1);
    // count register with reset > load > tick priority; pulses only follow a real move
    always_ff @(posedge clock)
        if (reset) begin
            count   <= '0;
            tc      <= 1'b0;
            wrapped <= 1'b0;
        end else if (load) begin
            count   <= (load_value > Limit) ? Limit : load_value;
            tc      <= 1'b0;
            wrapped <= 1'b0;
        end else begin
            tc      <= tick && !at_bound && next == bound;
            wrapped <= tick && at_bound && !hold;
            if (tick) count <= next;
        end
`ifdef COUNTER_UPDOWN_STICKY_EN
    // sticky overflow: a boundary tick sets it and beats a simultaneous clear
    always_ff @(posedge clock)
        if (reset) overflow <= 1'b0;
        else if (tick && !load && at_bound) overflow <= 1'b1;
        else if (clear_flags) overflow <= 1'b0;
`endif
endmodule

// File: tb/tb_counter_updown.sv
// tb_counter_updown: directed scoreboard bench for counter_updown (Size=5, Limit=20, Prescale=3)
module tb_counter_updown;
    localparam int SZ = 5;
    localparam int LIM = 20;
    localparam int PS = 3;
    typedef struct {
        int c;
        int t;
        int w;
        int o;
    } exp_t;
    logic clock = 1'b0;
    logic reset = 1'b0, enable = 1'b0, up = 1'b1, saturate = 1'b0, load = 1'b0, clear_flags = 1'b0;
    logic [SZ-1:0] load_value = '0;
    logic [SZ-1:0] count;
    logic tc, wrapped, overflow;
    int checks = 0, errors = 0;
    int mc = 0, mp = 0, mtc = 0, mw = 0, mo = 0;
    exp_t q[$];
    counter_updown #(.Size(SZ), .Limit(SZ'(LIM)), .Prescale(PS)) dut (
        .clock(clock), .reset(reset), .enable(enable), .up(up), .saturate(saturate),
        .load(load), .load_value(load_value),
`ifdef COUNTER_UPDOWN_STICKY_EN
        .clear_flags(clear_flags), .overflow(overflow),
`endif
        .count(count), .tc(tc), .wrapped(wrapped)
    );
`ifndef COUNTER_UPDOWN_STICKY_EN
    assign overflow = 1'b0;
`endif
    always #5 clock = ~clock;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask
    task automatic step(input logic en, input logic u, input logic s, input logic ld, input int lv, input logic rs);
        bit tk;
        enable = en; up = u; saturate = s; load = ld; load_value = SZ'(lv); reset = rs;
        if (rs) begin
            mc = 0; mp = 0; mtc = 0; mw = 0; mo = 0;
        end else if (ld) begin
            mc = (lv > LIM) ? LIM : lv; mp = 0; mtc = 0; mw = 0;
            if (clear_flags) mo = 0;
        end else begin
            tk = en && mp == PS - 1;
            if (en) mp = tk ? 0 : mp + 1;
            mtc = 0; mw = 0;
            if (clear_flags) mo = 0;
            if (tk && u) begin
                if (mc < LIM) begin mc++; mtc = (mc == LIM); end
                else begin mo = 1; if (!s) begin mc = 0; mw = 1; end end
            end else if (tk) begin
                if (mc > 0) begin mc--; mtc = (mc == 0); end
                else begin mo = 1; if (!s) begin mc = LIM; mw = 1; end end
            end
        end
        q.push_back('{mc, mtc, mw, mo});
        @(posedge clock);
        #1;
        begin
            exp_t e;
            e = q.pop_front();
            chk("count", 32'(count), 32'(e.c));
            chk("tc", 32'(tc), 32'(e.t));
            chk("wrapped", 32'(wrapped), 32'(e.w));
`ifdef COUNTER_UPDOWN_STICKY_EN
            chk("overflow", 32'(overflow), 32'(e.o));
`endif
        end
    endtask
    task automatic run(input int n, input logic u, input logic s);
        for (int i = 0; i < n; i++) step(1'b1, u, s, 1'b0, 0, 1'b0);
    endtask
    int tc_seen, wr_seen;
    initial begin
        @(posedge clock); #1;
        step(0, 1, 0, 0, 0, 1);
        step(0, 1, 0, 0, 0, 1);
        chk("reset_count", 32'(count), 0);
        tc_seen = 0; wr_seen = 0;
        for (int i = 0; i < 21 * PS; i++) begin
            step(1, 1, 0, 0, 0, 0);
            tc_seen += int'(tc); wr_seen += int'(wrapped);
        end
        chk("wrap_to_zero", 32'(count), 0);
        chk("wrap_tc_pulses", 32'(tc_seen), 1);
        chk("wrap_wr_pulses", 32'(wr_seen), 1);
        tc_seen = 0; wr_seen = 0;
        for (int i = 0; i < 25 * PS; i++) begin
            step(1, 1, 1, 0, 0, 0);
            tc_seen += int'(tc); wr_seen += int'(wrapped);
        end
        chk("sat_hold", 32'(count), 20);
        chk("sat_tc_pulses", 32'(tc_seen), 1);
        chk("sat_wr_pulses", 32'(wr_seen), 0);
`ifdef COUNTER_UPDOWN_STICKY_EN
        chk("overflow_set", 32'(overflow), 1);
        clear_flags = 1'b1;
        step(0, 1, 1, 0, 0, 0);
        clear_flags = 1'b0;
        chk("overflow_clr", 32'(overflow), 0);
`endif
        step(1, 0, 0, 1, 31, 0);
        chk("load_clamp", 32'(count), 20);
        chk("load_tc", 32'(tc), 0);
        run(21 * PS, 0, 0);
        chk("down_wrap", 32'(count), 20);
        step(0, 1, 0, 1, 0, 0);
        step(1, 1, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        chk("pre_hold", 32'(count), 0);
        step(1, 1, 0, 0, 0, 0);
        chk("pre_tick", 32'(count), 1);
        step(1, 1, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0);
        step(1, 1, 0, 1, 7, 0);
        chk("load_over_tick", 32'(count), 7);
        run(2, 1, 0);
        chk("load_pre_clear", 32'(count), 7);
        run(1, 1, 0);
        chk("after_load_tick", 32'(count), 8);
        run(PS + 1, 0, 0);
        run(2 * PS, 1, 0);
        step(1, 1, 0, 1, 13, 0);
        run(2, 1, 0);
        step(1, 1, 0, 0, 0, 1);
        chk("mid_reset", 32'(count), 0);
        run(PS - 1, 1, 0);
        chk("post_reset_wait", 32'(count), 0);
        run(1, 1, 0);
        chk("post_reset_tick", 32'(count), 1);
        for (int i = 0; i < 40; i++)
            step(1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)),
                 1'($urandom_range(7) == 0), int'($urandom_range(31)), 1'($urandom_range(31) == 0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
